// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types and constants for the forwarding/load-use scheduler
package pipe_pkg;

  // Operand mux select encodings
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Load-use stall FSM
  typedef enum logic {
    IDLE  = 1'b0,
    STALL = 1'b1
  } stallState_t;

  // Shadow copy of the instruction sitting in EX
  typedef struct packed {
    logic [4:0] rs;
    logic [4:0] rt;
    logic       usesRt;
    logic [4:0] dst;
    logic       regWrite;
    logic       memRead;
    logic       valid;
  } exStage_t;

  // Shadow copy of the instruction sitting in MEM
  typedef struct packed {
    logic [4:0] dst;
    logic       regWrite;
    logic       memRead;
    logic       valid;
  } memStage_t;

  // Shadow copy of the instruction sitting in WB
  typedef struct packed {
    logic [4:0] dst;
    logic       regWrite;
    logic       valid;
  } wbStage_t;

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - one operand's forward select from the MEM and WB shadow stages
module fwd_sel
  import pipe_pkg::*;
(
  input  logic [4:0] src,
  input  logic       srcUsed,
  input  memStage_t  memStage,
  input  wbStage_t   wbStage,
  output logic [1:0] sel
);

  // MEM wins over WB; a load in MEM has no data yet so it falls through to WB; $0 never forwards
  always_comb begin
    sel = FWD_RF;
    if (srcUsed && (src != 5'd0)) begin
      if (memStage.valid && memStage.regWrite && !memStage.memRead && (memStage.dst == src)) begin
        sel = FWD_EXMEM;
      end else if (wbStage.valid && wbStage.regWrite && (wbStage.dst == src)) begin
        sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/fwd_sched.sv
// rtl/fwd_sched.sv - forwarding selects, load-use stall and bubble insertion for the 5-stage pipe
module fwd_sched
  import pipe_pkg::*;
#(
  parameter int LOAD_LAT = 1
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic [4:0] IdRs,
  input  logic [4:0] IdRt,
  input  logic [4:0] IdDst,
  input  logic       IdUsesRt,
  input  logic       IdRegWrite,
  input  logic       IdMemRead,
  input  logic       IdValid,
  input  logic       Flush,
  output logic [1:0] ForwardA,
  output logic [1:0] ForwardB,
  output logic       Stall,
  output logic       PcWrite,
  output logic       IfIdWrite
);

  exStage_t    exQ;
  exStage_t    exD;
  memStage_t   memQ;
  wbStage_t    wbQ;
  stallState_t stateQ;
  stallState_t stateD;
  logic [1:0]  cntQ;
  logic [1:0]  cntD;
  logic        hazard;
  logic        stallInt;

  // The first stall cycle is the IDLE cycle that sees the hazard; the
  // counter then covers the remaining LOAD_LAT-1 cycles spent in STALL.
  localparam logic [1:0] CNT_LOAD = 2'(LOAD_LAT - 1);

  // Load in EX whose destination is read by the instruction in ID
  always_comb begin
    hazard = exQ.valid && exQ.memRead && (exQ.dst != 5'd0) && IdValid &&
             ((exQ.dst == IdRs) || (IdUsesRt && (exQ.dst == IdRt)));
  end

  // Next EX contents: the ID instruction, or a bubble when stalled, flushed or empty
  always_comb begin
    exD = '0;
    if (IdValid && !stallInt && !Flush) begin
      exD.rs       = IdRs;
      exD.rt       = IdRt;
      exD.usesRt   = IdUsesRt;
      exD.dst      = IdDst;
      exD.regWrite = IdRegWrite;
      exD.memRead  = IdMemRead;
      exD.valid    = 1'b1;
    end
  end

  // Shadow pipeline advances every cycle
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      exQ  <= '0;
      memQ <= '0;
      wbQ  <= '0;
    end else begin
      exQ           <= exD;
      memQ.dst      <= exQ.dst;
      memQ.regWrite <= exQ.regWrite;
      memQ.memRead  <= exQ.memRead;
      memQ.valid    <= exQ.valid;
      wbQ.dst       <= memQ.dst;
      wbQ.regWrite  <= memQ.regWrite;
      wbQ.valid     <= memQ.valid;
    end
  end

  // Stall FSM state register
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stateQ <= IDLE;
      cntQ   <= 2'd0;
    end else begin
      stateQ <= stateD;
      cntQ   <= cntD;
    end
  end

  // Stall FSM next state; Flush always wins and returns to IDLE
  always_comb begin
    stateD = stateQ;
    cntD   = cntQ;
    case (stateQ)
      IDLE: begin
        if (hazard && !Flush && (LOAD_LAT > 1)) begin
          stateD = STALL;
          cntD   = CNT_LOAD;
        end
      end
      STALL: begin
        if (Flush || (cntQ <= 2'd1)) begin
          stateD = IDLE;
          cntD   = 2'd0;
        end else begin
          cntD = cntQ - 2'd1;
        end
      end
      default: begin
        stateD = IDLE;
        cntD   = 2'd0;
      end
    endcase
  end

  // Stall FSM outputs: a hazard stalls in the same cycle it is seen
  always_comb begin
    stallInt  = ((stateQ == IDLE) && hazard && !Flush) || (stateQ == STALL);
    Stall     = stallInt;
    PcWrite   = !stallInt;
    IfIdWrite = !stallInt;
  end

  fwd_sel uFwdA (
    .src      (exQ.rs),
    .srcUsed  (1'b1),
    .memStage (memQ),
    .wbStage  (wbQ),
    .sel      (ForwardA)
  );

  fwd_sel uFwdB (
    .src      (exQ.rt),
    .srcUsed  (exQ.usesRt),
    .memStage (memQ),
    .wbStage  (wbQ),
    .sel      (ForwardB)
  );

endmodule

// File: tb/tb_fwd_sched.sv
// tb/tb_fwd_sched.sv - scoreboard bench for fwd_sched with LOAD_LAT 1 and 3
module tb_fwd_sched;

  logic       Clk;
  logic       Reset;
  logic [4:0] IdRs;
  logic [4:0] IdRt;
  logic [4:0] IdDst;
  logic       IdUsesRt;
  logic       IdRegWrite;
  logic       IdMemRead;
  logic       IdValid;
  logic       Flush;

  logic [1:0] fa1, fb1, fa3, fb3;
  logic       st1, pc1, ifid1, st3, pc3, ifid3;

  typedef struct {
    int         cyc;
    int         dutSel;
    string      tag;
    logic [1:0] fa;
    logic [1:0] fb;
    logic       st;
  } expEntry_t;

  expEntry_t sb[$];
  expEntry_t e;
  int        cyc;
  int        nCompared;
  int        nMismatch;

  fwd_sched #(.LOAD_LAT(1)) dut1 (
    .Clk(Clk), .Reset(Reset), .IdRs(IdRs), .IdRt(IdRt), .IdDst(IdDst),
    .IdUsesRt(IdUsesRt), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
    .IdValid(IdValid), .Flush(Flush), .ForwardA(fa1), .ForwardB(fb1),
    .Stall(st1), .PcWrite(pc1), .IfIdWrite(ifid1)
  );

  fwd_sched #(.LOAD_LAT(3)) dut3 (
    .Clk(Clk), .Reset(Reset), .IdRs(IdRs), .IdRt(IdRt), .IdDst(IdDst),
    .IdUsesRt(IdUsesRt), .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead),
    .IdValid(IdValid), .Flush(Flush), .ForwardA(fa3), .ForwardB(fb3),
    .Stall(st3), .PcWrite(pc3), .IfIdWrite(ifid3)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    nCompared++;
    if (got !== want) begin
      nMismatch++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Compare every expectation queued for the current cycle, mid-cycle
  always @(negedge Clk) begin
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e = sb.pop_front();
      if (e.dutSel == 1) begin
        checkVal({e.tag, ".L1.fa"}, 32'(fa1), 32'(e.fa));
        checkVal({e.tag, ".L1.fb"}, 32'(fb1), 32'(e.fb));
        checkVal({e.tag, ".L1.stall"}, 32'(st1), 32'(e.st));
        checkVal({e.tag, ".L1.pcWrite"}, 32'(pc1), 32'(!e.st));
        checkVal({e.tag, ".L1.ifIdWrite"}, 32'(ifid1), 32'(!e.st));
      end else begin
        checkVal({e.tag, ".L3.fa"}, 32'(fa3), 32'(e.fa));
        checkVal({e.tag, ".L3.fb"}, 32'(fb3), 32'(e.fb));
        checkVal({e.tag, ".L3.stall"}, 32'(st3), 32'(e.st));
        checkVal({e.tag, ".L3.pcWrite"}, 32'(pc3), 32'(!e.st));
        checkVal({e.tag, ".L3.ifIdWrite"}, 32'(ifid3), 32'(!e.st));
      end
    end
  end

  task automatic pushExp(input int d, input string tag, input logic [1:0] fa, input logic [1:0] fb, input logic st);
    expEntry_t x;
    x.cyc = cyc; x.dutSel = d; x.tag = tag; x.fa = fa; x.fb = fb; x.st = st;
    sb.push_back(x);
  endtask

  task automatic pushBoth(input string tag, input logic [1:0] fa, input logic [1:0] fb, input logic st);
    pushExp(1, tag, fa, fb, st);
    pushExp(3, tag, fa, fb, st);
  endtask

  task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst,
                       input logic usesRt, input logic rw, input logic mr, input logic vld, input logic fl);
    @(posedge Clk);
    #1;
    cyc++;
    IdRs = rs; IdRt = rt; IdDst = dst; IdUsesRt = usesRt;
    IdRegWrite = rw; IdMemRead = mr; IdValid = vld; Flush = fl;
  endtask

  task automatic nop();
    drive(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic alu(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dst);
    drive(rs, rt, dst, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic load(input logic [4:0] rs, input logic [4:0] dst);
    drive(rs, 5'd0, dst, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, got running want finished");
    $fatal(1);
  end

  initial begin
    cyc = 0; nCompared = 0; nMismatch = 0;
    Reset = 1'b1;
    IdRs = '0; IdRt = '0; IdDst = '0; IdUsesRt = 0;
    IdRegWrite = 0; IdMemRead = 0; IdValid = 0; Flush = 0;

    nop();                        pushBoth("reset", 2'b00, 2'b00, 1'b0);
    nop(); Reset = 1'b0;          pushBoth("postReset", 2'b00, 2'b00, 1'b0);

    // add $3,$1,$2 ; sub $4,$3,$5 -> EX/MEM forward on A only
    alu(5'd1, 5'd2, 5'd3);        pushBoth("c1", 2'b00, 2'b00, 1'b0);
    alu(5'd3, 5'd5, 5'd4);        pushBoth("c2", 2'b00, 2'b00, 1'b0);
    alu(5'd1, 5'd2, 5'd3);        pushBoth("subFwd", 2'b01, 2'b00, 1'b0);
    // add $3 ; nop ; or $6,$7,$3 -> MEM/WB forward on B
    nop();                        pushBoth("c4", 2'b00, 2'b00, 1'b0);
    alu(5'd7, 5'd3, 5'd6);        pushBoth("c5", 2'b00, 2'b00, 1'b0);
    nop();                        pushBoth("orFwd", 2'b00, 2'b10, 1'b0);
    // two writers of $3 in MEM and WB -> MEM wins
    alu(5'd1, 5'd2, 5'd3);        pushBoth("c7", 2'b00, 2'b00, 1'b0);
    alu(5'd1, 5'd2, 5'd3);        pushBoth("c8", 2'b00, 2'b00, 1'b0);
    alu(5'd3, 5'd3, 5'd11);       pushBoth("c9", 2'b00, 2'b00, 1'b0);
    nop();                        pushBoth("memPrio", 2'b01, 2'b01, 1'b0);
    // writes of $0 are never forwarded and a load of $0 never stalls
    drive(5'd1, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
                                  pushBoth("c11", 2'b00, 2'b00, 1'b0);
    alu(5'd0, 5'd0, 5'd12);       pushBoth("c12", 2'b00, 2'b00, 1'b0);
    load(5'd2, 5'd0);             pushBoth("r0MemFwd", 2'b00, 2'b00, 1'b0);
    alu(5'd0, 5'd0, 5'd12);       pushBoth("r0NoStall", 2'b00, 2'b00, 1'b0);
    nop();                        pushBoth("r0WbFwd", 2'b00, 2'b00, 1'b0);
    nop();                        pushBoth("c16", 2'b00, 2'b00, 1'b0);

    // lw $8,0($9) ; add $10,$8,$8 (held in ID while stalled)
    load(5'd9, 5'd8);             pushBoth("c17", 2'b00, 2'b00, 1'b0);
    alu(5'd8, 5'd8, 5'd10);       pushBoth("luDetect", 2'b00, 2'b00, 1'b1);
    alu(5'd8, 5'd8, 5'd10);       pushExp(1, "luBubble", 2'b00, 2'b00, 1'b0);
                                  pushExp(3, "luStall2", 2'b00, 2'b00, 1'b1);
    alu(5'd8, 5'd8, 5'd10);       pushExp(1, "luFwd", 2'b10, 2'b10, 1'b0);
                                  pushExp(3, "luStall3", 2'b00, 2'b00, 1'b1);
    alu(5'd8, 5'd8, 5'd10);       pushBoth("luRelease", 2'b00, 2'b00, 1'b0);
    nop();                        pushBoth("lu3Sel", 2'b00, 2'b00, 1'b0);

    // hazard and Flush together: no stall, bubble into EX, FSM stays idle
    load(5'd9, 5'd8);             pushBoth("c23", 2'b00, 2'b00, 1'b0);
    drive(5'd8, 5'd8, 5'd8, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
                                  pushBoth("flushHaz", 2'b00, 2'b00, 1'b0);
    alu(5'd8, 5'd8, 5'd10);       pushBoth("flushIdle", 2'b00, 2'b00, 1'b0);
    nop();                        pushBoth("flushBubble", 2'b10, 2'b10, 1'b0);

    // reset asserted while LOAD_LAT=3 instance sits in STALL
    nop();                        pushBoth("c27", 2'b00, 2'b00, 1'b0);
    load(5'd9, 5'd8);             pushBoth("c28", 2'b00, 2'b00, 1'b0);
    alu(5'd8, 5'd8, 5'd10);       pushBoth("preRst", 2'b00, 2'b00, 1'b1);
    alu(5'd8, 5'd8, 5'd10); Reset = 1'b1;
                                  pushBoth("rstMid", 2'b00, 2'b00, 1'b0);
    nop(); Reset = 1'b0;          pushBoth("rstRelease", 2'b00, 2'b00, 1'b0);
    nop();                        pushBoth("tail", 2'b00, 2'b00, 1'b0);

    @(negedge Clk);
    #1;
    checkVal("sbDrained", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
    $finish;
  end

endmodule
